writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-back stage that sits directly upstream of the register file's single write port. It merges two result sources: the in-order pipeline result (primary, never stalls) and the multicycle multiply/divide unit (secondary, valid/ready). It drives one registered register-file write per cycle. Secondary results wait in a small FIFO and drain in cycles where the primary source is idle. A pending-register mask lets decode stall on queued writes.

## Interface
- DEPTH, 4, secondary FIFO entries; power of two, ≥2
- DATA_WIDTH, 32, result width
- clock  in  1  rising-edge clock
- resetN  in  1  reset, asynchronous, active-low
- primaryValid  in  1  primary result present this cycle
- primaryAddress  in  5  primary destination register
- primaryData  in  DATA_WIDTH  primary result
- secondaryValid  in  1  secondary result offered
- secondaryReady  out  1  FIFO can accept a secondary result
- secondaryAddress  in  5  secondary destination register
- secondaryData  in  DATA_WIDTH  secondary result
- writeEnabled  out  1  register-file write strobe (registered)
- writeAddress  out  5  register-file write address (registered)
- writeData  out  DATA_WIDTH  register-file write data (registered)
- pendingMask  out  32  bit r set when a live FIFO entry targets r; bit 0 always 0
- queueCount  out  $clog2(DEPTH)+1  occupied FIFO slots, live or killed
- readAddressA/B, readDataA/B, forwardDataA/B: present only with WRITEBACK_BYPASS_EN (see Configuration)

## Operation
- Secondary accept: secondaryValid && secondaryReady. secondaryReady = (queueCount < DEPTH), computed from the registered count; a pop in the same cycle does not raise it.
- Accepted secondary with address 0 is discarded and not enqueued. Otherwise it is pushed at the tail with live=1.
- Output register load, evaluated every cycle in priority order:
  1. primaryValid && primaryAddress≠0 → load primary and assert writeEnabled next cycle.
  2. Else, FIFO non-empty → pop the head. Load it with writeEnabled=1 if the head is live; a killed head loads writeEnabled=0.
  3. Else → writeEnabled=0; writeAddress/writeData hold their previous values.
- Primary with address 0 counts as idle for arbitration, so the FIFO may drain that cycle.
- WAW kill: when a primary with address r≠0 is loaded, every FIFO entry targeting r has its live bit cleared. This includes a secondary with address r accepted in the same cycle, which counts as older than the primary. Killed entries still occupy their slot until popped.
- pendingMask covers live entries only, and includes an entry pushed this cycle from the next cycle on.
- Push and pop in the same cycle: queueCount unchanged. The FIFO head is never the entry being pushed that cycle.

## Timing
- Primary: accepted cycle N → write strobe in cycle N+1, so the register file commits at the end of N+1. One cycle of latency.
- Secondary: accepted cycle N → earliest strobe in cycle N+2. If primary is valid every cycle, the entry waits indefinitely; no starvation guard exists, by design.
- Reset (resetN low, asynchronous): FIFO emptied, queueCount=0, secondaryReady=1, writeEnabled=0, writeAddress=0, writeData=0, pendingMask=0.
- Reset asserted mid-drain drops all queued entries; no partial write is issued.
- Pointers wrap modulo DEPTH; queueCount distinguishes full from empty.

## Configuration
- WRITEBACK_BYPASS_EN defined: adds inputs readAddressA/B (5 bits) and readDataA/B (DATA_WIDTH, from the register file), and outputs forwardDataA/B.
  - forwardDataX = writeData when writeEnabled && writeAddress==readAddressX && readAddressX≠0.
  - Otherwise forwardDataX = readDataX.
  - The forward path is purely combinational; it closes the same-cycle write/read gap.
- WRITEBACK_BYPASS_EN undefined: these ports and the forward logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: writeEnabled=0, secondaryReady=1, queueCount=0, pendingMask=0.
- Primary r5=0x1234 in cycle 1 → writeEnabled=1, writeAddress=5, writeData=0x1234 in cycle 2; primary r0 → no strobe.
- Four secondary pushes (r1..r4) while primary busy → queueCount=4, secondaryReady=0, pendingMask=0x1E. After primary stops, strobes r1,r2,r3,r4 on four consecutive cycles, and the mask clears bit by bit.
- Secondary r7=0xAAAA queued, then primary r7=0xBBBB → only 0xBBBB is written to r7. The killed slot pops with writeEnabled=0, and pendingMask bit 7 clears in the cycle after the primary.
- resetN pulsed low mid-drain with 3 entries queued → outputs zero immediately, no further strobes, secondaryReady=1.
- With WRITEBACK_BYPASS_EN: writeEnabled for r9=0x55, readAddressA=9, readDataA=0x11 → forwardDataA=0x55. readAddressB=0 → forwardDataB=readDataB.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: write-back merge stage in front of the register file's
// single write port. The primary (in-order) result always wins the port.
// Secondary (multiply/divide) results wait in a small FIFO and drain in
// cycles where the primary source is idle.
//
// Optional feature macro: WRITEBACK_BYPASS_EN
//   When defined, this adds two combinational read-forward ports. They let a
//   same-cycle register-file read observe the write currently being strobed.
//   When undefined, those ports and the forwarding logic are absent.
module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    primaryValid,
  input  logic [4:0]              primaryAddress,
  input  logic [DATA_WIDTH-1:0]   primaryData,
  input  logic                    secondaryValid,
  output logic                    secondaryReady,
  input  logic [4:0]              secondaryAddress,
  input  logic [DATA_WIDTH-1:0]   secondaryData,
  output logic                    writeEnabled,
  output logic [4:0]              writeAddress,
  output logic [DATA_WIDTH-1:0]   writeData,
  output logic [31:0]             pendingMask,
  output logic [$clog2(DEPTH):0]  queueCount
`ifdef WRITEBACK_BYPASS_EN
  ,
  input  logic [4:0]              readAddressA,
  input  logic [4:0]              readAddressB,
  input  logic [DATA_WIDTH-1:0]   readDataA,
  input  logic [DATA_WIDTH-1:0]   readDataB,
  output logic [DATA_WIDTH-1:0]   forwardDataA,
  output logic [DATA_WIDTH-1:0]   forwardDataB
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage. Address and data need no reset: an entry only matters
  // while its live bit or its occupancy says so.
  logic [4:0]            addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [DEPTH-1:0] live_reg;
  logic [DEPTH-1:0] live_next;
  logic [PTR_W-1:0] head_ptr_reg;
  logic [PTR_W-1:0] tail_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic             write_en_reg;
  logic [4:0]       write_addr_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;

  logic        primary_load;
  logic        push;
  logic        pop;
  logic        queue_nonempty;
  logic        push_killed;
  logic [31:0] pending_mask;

  // A primary with address 0 is treated as idle, so the FIFO may drain then.
  assign primary_load   = primaryValid && (primaryAddress != 5'd0);
  assign queue_nonempty = (count_reg != '0);

  // Ready is based on the registered count only. A pop in the same cycle
  // does not raise it, which keeps the ready path short.
  assign secondaryReady = (count_reg < CNT_W'(DEPTH));

  // A secondary result for r0 is accepted but never stored.
  assign push = secondaryValid && secondaryReady && (secondaryAddress != 5'd0);

  // The head is popped only when the primary does not claim the port. The
  // head can never be the slot written this cycle: when the queue is empty
  // nothing pops, and when it is full nothing pushes.
  assign pop = !primary_load && queue_nonempty;

  // A secondary accepted in the same cycle as a primary to the same register
  // is older than that primary, so it enters the queue already killed.
  assign push_killed = primary_load && (secondaryAddress == primaryAddress);

  // Per-slot live bit. A fresh push sets it, a pop frees it, and a primary
  // write to the same register kills it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      logic is_tail;
      logic is_head;
      logic waw_hit;
      assign is_tail = (tail_ptr_reg == PTR_W'(gi));
      assign is_head = (head_ptr_reg == PTR_W'(gi));
      assign waw_hit = primary_load && (addr_mem[gi] == primaryAddress);
      assign live_next[gi] = (push && is_tail) ? !push_killed :
                             (pop  && is_head) ? 1'b0 :
                             waw_hit           ? 1'b0 :
                                                 live_reg[gi];
    end
  endgenerate

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO control state: pointers, count and live bits.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      live_reg     <= '0;
    end else begin
      if (push) tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
      if (pop)  head_ptr_reg <= head_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      live_reg  <= live_next;
    end
  end

  // FIFO payload write at the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_ptr_reg] <= secondaryAddress;
      data_mem[tail_ptr_reg] <= secondaryData;
    end
  end

  // Output register in priority order: primary, then FIFO head, then idle.
  // A killed head still loads address/data but does not strobe.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      write_en_reg   <= 1'b0;
      write_addr_reg <= 5'd0;
      write_data_reg <= '0;
    end else if (primary_load) begin
      write_en_reg   <= 1'b1;
      write_addr_reg <= primaryAddress;
      write_data_reg <= primaryData;
    end else if (pop) begin
      write_en_reg   <= live_reg[head_ptr_reg];
      write_addr_reg <= addr_mem[head_ptr_reg];
      write_data_reg <= data_mem[head_ptr_reg];
    end else begin
      write_en_reg   <= 1'b0;
    end
  end

  // Pending-register mask from live entries. Entries never target r0, and
  // bit 0 is forced clear anyway.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_reg[i]) pending_mask[addr_mem[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign writeEnabled = write_en_reg;
  assign writeAddress = write_addr_reg;
  assign writeData    = write_data_reg;
  assign pendingMask  = pending_mask;
  assign queueCount   = count_reg;

`ifdef WRITEBACK_BYPASS_EN
  // Forward the write in flight so a same-cycle read sees the new value.
  assign forwardDataA = (writeEnabled && (writeAddress == readAddressA) &&
                         (readAddressA != 5'd0)) ? writeData : readDataA;
  assign forwardDataB = (writeEnabled && (writeAddress == readAddressB) &&
                         (readAddressB != 5'd0)) ? writeData : readDataB;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed scenarios followed by random traffic. The
// outputs are checked on every falling edge against a queue-based model.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          primaryValid = 1'b0;
  logic [4:0]    primaryAddress = '0;
  logic [DW-1:0] primaryData = '0;
  logic          secondaryValid = 1'b0;
  logic [4:0]    secondaryAddress = '0;
  logic [DW-1:0] secondaryData = '0;
  logic          secondaryReady;
  logic          writeEnabled;
  logic [4:0]    writeAddress;
  logic [DW-1:0] writeData;
  logic [31:0]   pendingMask;
  logic [$clog2(DEPTH):0] queueCount;
`ifdef WRITEBACK_BYPASS_EN
  logic [4:0]    readAddressA = '0;
  logic [4:0]    readAddressB = '0;
  logic [DW-1:0] readDataA = '0;
  logic [DW-1:0] readDataB = '0;
  logic [DW-1:0] forwardDataA;
  logic [DW-1:0] forwardDataB;
`endif

  writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .resetN(resetN),
    .primaryValid(primaryValid), .primaryAddress(primaryAddress), .primaryData(primaryData),
    .secondaryValid(secondaryValid), .secondaryReady(secondaryReady),
    .secondaryAddress(secondaryAddress), .secondaryData(secondaryData),
    .writeEnabled(writeEnabled), .writeAddress(writeAddress), .writeData(writeData),
    .pendingMask(pendingMask), .queueCount(queueCount)
`ifdef WRITEBACK_BYPASS_EN
    , .readAddressA(readAddressA), .readAddressB(readAddressB),
    .readDataA(readDataA), .readDataB(readDataB),
    .forwardDataA(forwardDataA), .forwardDataB(forwardDataB)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit compare_en = 1'b0;

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    bit            live;
  } entry_t;

  entry_t        q[$];
  bit            exp_we = 1'b0;
  logic [4:0]    exp_wa = '0;
  logic [DW-1:0] exp_wd = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of the reference behaviour, based on inputs sampled at the edge.
  task automatic model_step();
    bit     ready = (q.size() < DEPTH);
    bit     prim = primaryValid && (primaryAddress != 5'd0);
    int     old_size = q.size();
    entry_t head;
    head = '{addr: 5'd0, data: '0, live: 1'b0};
    if (!prim && old_size > 0) head = q.pop_front();
    if (secondaryValid && ready && secondaryAddress != 5'd0)
      q.push_back('{addr: secondaryAddress, data: secondaryData, live: 1'b1});
    if (prim) begin
      foreach (q[i]) if (q[i].addr == primaryAddress) q[i].live = 1'b0;
      exp_we = 1'b1;
      exp_wa = primaryAddress;
      exp_wd = primaryData;
    end else if (old_size > 0) begin
      exp_we = head.live;
      exp_wa = head.addr;
      exp_wd = head.data;
    end else begin
      exp_we = 1'b0;
    end
  endtask

  // Model state follows the DUT's clock and asynchronous reset.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      q.delete();
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (compare_en) begin
      check("cmp_we",    32'(writeEnabled),   32'(exp_we));
      check("cmp_waddr", 32'(writeAddress),   32'(exp_wa));
      check("cmp_wdata", writeData,           exp_wd);
      check("cmp_ready", 32'(secondaryReady), 32'(q.size() < DEPTH));
      check("cmp_count", 32'(queueCount),     32'(q.size()));
      check("cmp_mask",  pendingMask,         model_mask());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit pv, logic [4:0] pa, logic [DW-1:0] pd,
                       bit sv, logic [4:0] sa, logic [DW-1:0] sd);
    primaryValid = pv; primaryAddress = pa; primaryData = pd;
    secondaryValid = sv; secondaryAddress = sa; secondaryData = sd;
  endtask

  initial begin
    logic [31:0] m;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    compare_en = 1'b1;
    tick();

    // Reset then idle.
    check("rst_we",    32'(writeEnabled),   0);
    check("rst_ready", 32'(secondaryReady), 1);
    check("rst_count", 32'(queueCount),     0);
    check("rst_mask",  pendingMask,         0);

    // Primary r5, then primary r0.
    drive(1, 5, 32'h1234, 0, 0, 0); tick();
    check("prim_we",    32'(writeEnabled), 1);
    check("prim_waddr", 32'(writeAddress), 5);
    check("prim_wdata", writeData,         32'h1234);
    drive(1, 0, 32'hDEAD, 0, 0, 0); tick();
    check("prim_r0_we", 32'(writeEnabled), 0);

    // Four secondary pushes while the primary is busy.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 10, 32'h100 + i, 1, 5'(i), 32'hA0 + i); tick();
    end
    check("full_count", 32'(queueCount),     4);
    check("full_ready", 32'(secondaryReady), 0);
    check("full_mask",  pendingMask,         32'h1E);
    check("model_mask_full", model_mask(),   32'h1E);
    drive(0, 0, 0, 0, 0, 0);
    m = 32'h1E;
    for (int i = 1; i <= 4; i++) begin
      tick();
      m[i] = 1'b0;
      check("drain_we",    32'(writeEnabled), 1);
      check("drain_waddr", 32'(writeAddress), 32'(i));
      check("drain_wdata", writeData,         32'hA0 + i);
      check("drain_mask",  pendingMask,       m);
    end
    tick();
    check("drained_we", 32'(writeEnabled), 0);

    // WAW kill: queued r7 then primary r7.
    drive(1, 10, 32'h1, 1, 7, 32'hAAAA); tick();
    check("waw_mask_pre", pendingMask, 32'h80);
    drive(1, 7, 32'hBBBB, 0, 0, 0); tick();
    check("waw_we",    32'(writeEnabled), 1);
    check("waw_waddr", 32'(writeAddress), 7);
    check("waw_wdata", writeData,         32'hBBBB);
    check("waw_mask",  pendingMask,       0);
    check("waw_count", 32'(queueCount),   1);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("waw_pop_we",    32'(writeEnabled), 0);
    check("waw_pop_count", 32'(queueCount),   0);

    // Same-cycle secondary and primary to one register: secondary is older.
    drive(1, 12, 32'hC0, 1, 12, 32'hC1); tick();
    check("same_mask",  pendingMask,     0);
    check("same_count", 32'(queueCount), 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("same_pop_we", 32'(writeEnabled), 0);

`ifdef WRITEBACK_BYPASS_EN
    drive(1, 9, 32'h55, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    readAddressA = 9; readDataA = 32'h11;
    readAddressB = 0; readDataB = 32'h77;
    #1;
    check("fwd_a", forwardDataA, 32'h55);
    check("fwd_b", forwardDataB, 32'h77);
    readAddressA = 3;
    #1;
    check("fwd_a_miss", forwardDataA, 32'h11);
    tick();
`endif

    // Reset mid-drain with three entries queued.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 20, 32'h0, 1, 5'(i + 16), 32'h300 + i); tick();
    end
    drive(0, 0, 0, 0, 0, 0); tick();
    check("pre_rst_waddr", 32'(writeAddress), 17);
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_we",    32'(writeEnabled),   0);
    check("mid_rst_waddr", 32'(writeAddress),   0);
    check("mid_rst_wdata", writeData,           0);
    check("mid_rst_ready", 32'(secondaryReady), 1);
    check("mid_rst_count", 32'(queueCount),     0);
    check("mid_rst_mask",  pendingMask,         0);
    @(posedge clock);
    #1 resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_we", 32'(writeEnabled), 0);
    end

    // Random traffic with a small address range to force collisions.
    for (int phase = 0; phase < 4; phase++) begin
      int pv_pct = (phase == 0) ? 20 : (phase == 1) ? 50 : (phase == 2) ? 90 : 35;
      for (int c = 0; c < 400; c++) begin
        drive($urandom_range(0, 99) < pv_pct, 5'($urandom_range(0, 7)), $urandom(),
              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom());
        tick();
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 2) tick();
    check("final_count", 32'(queueCount), 0);

    compare_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
